// File: rtl/booth_mul32_pkg.sv
// Shared constants and types for the radix-2 Booth multiplier.
// Imported by the top and its adder.
package booth_mul32_pkg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 6;
   localparam int NBLK  = WIDTH / 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      NOP = 2'd0,
      ADD = 2'd1,
      SUB = 2'd2
   } booth_sel_e;

   function automatic booth_sel_e booth_sel(
      input logic q0,
      input logic q1
   );
      booth_sel_e s;
      case ({q0, q1})
         2'b01:   s = ADD;
         2'b10:   s = SUB;
         default: s = NOP;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/booth_mul32_add32.sv
// 32-bit two-level carry-lookahead adder (4-bit groups).
// Overflow is carry-into-MSB xor carry-out.
module booth_mul32_add32
   import booth_mul32_pkg::*;
(
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] c;
   logic [NBLK-1:0]  bg;
   logic [NBLK-1:0]  bp;
   logic [NBLK:0]    bc;

   always_comb begin
      g     = a_i & b_i;
      p     = a_i ^ b_i;
      c     = '0;
      bg    = '0;
      bp    = '0;
      bc    = '0;
      bc[0] = cin_i;
      for (int k = 0; k < NBLK; k++) begin
         bg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         bp[k] = &p[4*k +: 4];
         bc[k+1] = bg[k] | (bp[k] & bc[k]);
         c[4*k] = bc[k];
         c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
         c[4*k+2] = g[4*k+1]
                  | (p[4*k+1] & g[4*k])
                  | (p[4*k+1] & p[4*k] & bc[k]);
         c[4*k+3] = g[4*k+2]
                  | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
      end
   end

   assign sum_o  = p ^ c;
   assign cout_o = bc[NBLK];
   assign ovf_o  = c[WIDTH-1] ^ bc[NBLK];

endmodule

// File: rtl/booth_mul32.sv
// Sequential radix-2 Booth multiplier, 32x32 -> signed 64-bit.
// One iteration per clock through the shared CLA adder.
module booth_mul32
   import booth_mul32_pkg::*;
(
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             q1_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;

   booth_sel_e       sel;
   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH-1:0] add_sum;
   logic             add_ovf;
   logic             unused_cout;
   logic [WIDTH-1:0] sum_d;
   logic             ovf_d;
   logic             msb_d;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] q_d;
   logic             q1_d;

   always_comb begin
      sel     = booth_sel(q_q[0], q1_q);
      add_b   = (sel == SUB) ? ~m_q : m_q;
      add_cin = (sel == SUB);
   end

   booth_mul32_add32 add32 (
      .a_i    (a_q),
      .b_i    (add_b),
      .cin_i  (add_cin),
      .sum_o  (add_sum),
      .cout_o (unused_cout),
      .ovf_o  (add_ovf)
   );

   // Sign of the true 33-bit sum feeds the shift, so A-M with M=min is safe
   always_comb begin
      sum_d = (sel == NOP) ? a_q : add_sum;
      ovf_d = (sel == NOP) ? 1'b0 : add_ovf;
      msb_d = sum_d[WIDTH-1] ^ ovf_d;
      a_d   = {msb_d, sum_d[WIDTH-1:1]};
      q_d   = {sum_d[0], q_q[WIDTH-1:1]};
      q1_d  = q_q[0];
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= IDLE;
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         q1_q    <= 1'b0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  m_q     <= multiplicand;
                  q_q     <= multiplier;
                  a_q     <= '0;
                  q1_q    <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RUN: begin
               a_q   <= a_d;
               q_q   <= q_d;
               q1_q  <= q1_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  hi_q    <= a_d;
                  lo_q    <= q_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_booth_mul32.sv
// Bench for booth_mul32: directed corner products, random operands
// against a plain signed-multiply model, back-to-back, abort and busy.
module tb_booth_mul32;

   logic        clock = 1'b0;
   logic        clear;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   booth_mul32 dut (
      .clock        (clock),
      .clear        (clear),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .hi           (hi),
      .lo           (lo)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
      longint a;
      longint b;
      a = longint'($signed(m));
      b = longint'($signed(q));
      return 64'(a * b);
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0: v = 32'h8000_0000;
         1: v = 32'h0000_0000;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'h7FFF_FFFF;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [31:0] m, input logic [31:0] q);
      @(negedge clock);
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      @(negedge clock);
      start        = 1'b0;
      multiplicand = $urandom;
      multiplier   = $urandom;
   endtask

   task automatic wait_done(output int n, output int bn, output bit held);
      logic [63:0] hold;
      hold = {hi, lo};
      n    = 0;
      bn   = 0;
      held = 1'b1;
      while (!done && n < 100) begin
         if (busy) bn++;
         if ({hi, lo} !== hold) held = 1'b0;
         @(negedge clock);
         n++;
      end
   endtask

   task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                         input logic [63:0] exp, input string tag);
      int n;
      int bn;
      bit held;
      issue(m, q);
      wait_done(n, bn, held);
      chk({tag, "_lat"}, 64'(n), 64'd32);
      chk({tag, "_busy"}, 64'(bn), 64'd32);
      chk({tag, "_hold"}, 64'(held), 64'd1);
      chk({tag, "_prod"}, {hi, lo}, exp);
      @(negedge clock);
      chk({tag, "_pulse"}, {62'd0, busy, done}, 64'd0);
      chk({tag, "_keep"}, {hi, lo}, exp);
   endtask

   initial begin
      int n;
      int bn;
      int dn;
      bit held;
      logic [31:0] m1;
      logic [31:0] q1;

      clear        = 1'b1;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (3) @(negedge clock);
      chk("rst_in", {30'd0, busy, done, hi, lo}, 64'd0);
      clear = 1'b0;
      @(negedge clock);
      chk("rst_out", {30'd0, busy, done, hi, lo}, 64'd0);

      run_op(32'd6, 32'd7, 64'h0000_0000_0000_002A, "pos");
      run_op(32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "mix");
      run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "minsq");
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "neg");

      issue(32'h7FFF_FFFF, 32'h7FFF_FFFF);
      wait_done(n, bn, held);
      chk("b2b1_lat", 64'(n), 64'd32);
      chk("b2b1_prod", {hi, lo}, 64'h3FFF_FFFF_0000_0001);
      multiplicand = 32'd2;
      multiplier   = 32'd3;
      start        = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("b2b2_acc", {63'd0, busy}, 64'd1);
      wait_done(n, bn, held);
      chk("b2b2_lat", 64'(n), 64'd32);
      chk("b2b2_hold", 64'(held), 64'd1);
      chk("b2b2_prod", {hi, lo}, 64'd6);
      @(negedge clock);
      chk("b2b2_pulse", {63'd0, done}, 64'd0);

      for (int i = 0; i < 24; i++) begin
         m1 = pick();
         q1 = pick();
         run_op(m1, q1, ref_mul(m1, q1), "rnd");
      end

      m1 = $urandom;
      q1 = $urandom;
      issue(m1, q1);
      repeat (5) @(negedge clock);
      multiplicand = $urandom;
      multiplier   = $urandom;
      start        = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_done(n, bn, held);
      chk("ign_lat", 64'(n), 64'd26);
      chk("ign_prod", {hi, lo}, ref_mul(m1, q1));
      @(negedge clock);

      issue(32'h1234_5678, 32'h9ABC_DEF0);
      repeat (10) @(negedge clock);
      chk("clr_busy_pre", {63'd0, busy}, 64'd1);
      clear = 1'b1;
      #1;
      chk("clr_now", {30'd0, busy, done, hi, lo}, 64'd0);
      @(negedge clock);
      clear = 1'b0;
      dn = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (done) dn++;
      end
      chk("clr_nodone", 64'(dn), 64'd0);
      chk("clr_idle", {30'd0, busy, done, hi, lo}, 64'd0);

      run_op(32'hFFFF_FFF9, 32'd9, ref_mul(32'hFFFF_FFF9, 32'd9), "recov");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
